// File: rtl/ex_lsu_req_unit_if.sv
// Data SRAM request bus between the EX-stage LSU front end (master) and memory (slave).
// Valid/ready: a request transfers on a cycle with data_sram_req & data_sram_addr_ok; the master keeps addr/wr/wstrb/size/wdata stable while req is high.
interface ex_lsu_req_unit_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_size,
    output data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_size,
    input  data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok
  );
endinterface

// File: rtl/ex_lsu_req_unit.sv
// EX-stage load/store request front end: registers one op, translates it (direct/DMW/TLB),
// raises alignment/TLB exceptions, issues it on the data SRAM bus and tracks in-flight requests.
module ex_lsu_req_unit #(
  parameter  int N_DMW     = 2,
  parameter  int MAX_OUTST = 2,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  // Valid/ready: an op is accepted on a cycle with in_valid & in_ready; in_ready depends only on state.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_vaddr,
  input  logic                 in_is_load,
  input  logic                 in_is_store,
  input  logic [1:0]           in_size,
  input  logic [31:0]          in_wdata,
  input  logic                 flush,
  input  logic [1:0]           crmd_plv,
  input  logic                 csr_direct,
  input  logic [1:0]           crmd_datm,
  input  logic [3*N_DMW-1:0]   dmw_vseg,
  input  logic [3*N_DMW-1:0]   dmw_pseg,
  input  logic [N_DMW-1:0]     dmw_plv0,
  input  logic [N_DMW-1:0]     dmw_plv3,
  input  logic [2*N_DMW-1:0]   dmw_mat,
  output logic [18:0]          s1_vppn,
  output logic                 s1_va_bit12,
  input  logic                 s1_found,
  input  logic                 s1_v,
  input  logic                 s1_d,
  input  logic [19:0]          s1_ppn,
  input  logic [5:0]           s1_ps,
  input  logic [1:0]           s1_plv,
  input  logic [1:0]           s1_mat,
  ex_lsu_req_unit_if.master    sram,
  output logic [1:0]           datm,
  output logic                 resp_valid,
  output logic                 exc_valid,
  output logic [5:0]           exc_vec,
  output logic [31:0]          exc_badv,
  output logic [CNT_W-1:0]     outst_cnt,
  output logic                 dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [31:0]     op_vaddr;
  logic            op_load, op_store;
  logic [1:0]      op_size;
  logic [31:0]     op_wdata;
  logic [CNT_W-1:0] cancel_cnt, outst_nxt;

  logic            addr_ok, data_ok, issue, req, accept;
  logic            ale, dmw_hit, exc_any;
  logic [2:0]      dmw_pseg_sel;
  logic [1:0]      dmw_mat_sel, xlat_mat;
  logic [31:0]     xlat_paddr;
  logic [5:0]      vec;

  assign addr_ok = sram.data_sram_addr_ok;
  assign data_ok = sram.data_sram_data_ok;
  assign issue   = (state == S_ISSUE);
  // An op offered in a flush cycle is handshaken but dropped with the rest of the pipeline.
  assign accept  = in_valid && in_ready && !flush;

  // Translation and exception checks, all from the held op.
  always_comb begin
    ale = ((op_size == 2'd1) && op_vaddr[0]) || ((op_size == 2'd2) && (op_vaddr[1:0] != 2'b00));

    dmw_hit      = 1'b0;
    dmw_pseg_sel = 3'd0;
    dmw_mat_sel  = 2'd0;
    for (int i = N_DMW - 1; i >= 0; i--) begin
      if ((dmw_vseg[3*i +: 3] == op_vaddr[31:29]) &&
          ((dmw_plv0[i] && (crmd_plv == 2'd0)) || (dmw_plv3[i] && (crmd_plv == 2'd3)))) begin
        dmw_hit      = 1'b1;
        dmw_pseg_sel = dmw_pseg[3*i +: 3];
        dmw_mat_sel  = dmw_mat[2*i +: 2];
      end
    end

    if (csr_direct) begin
      xlat_paddr = op_vaddr;
      xlat_mat   = crmd_datm;
    end else if (dmw_hit) begin
      xlat_paddr = {dmw_pseg_sel, op_vaddr[28:0]};
      xlat_mat   = dmw_mat_sel;
    end else begin
      xlat_paddr = (s1_ps == 6'd21) ? {s1_ppn[19:9], op_vaddr[20:0]} : {s1_ppn, op_vaddr[11:0]};
      xlat_mat   = s1_mat;
    end

    // Priority-encoded so exactly one cause bit is ever set.
    vec = 6'b000000;
    if (ale)                          vec = 6'b100000;
    else if (!csr_direct && !dmw_hit) begin
      if (!s1_found)                  vec = 6'b010000;
      else if (!s1_v)                 vec = {2'b00, op_load, op_store, 2'b00};
      else if (crmd_plv > s1_plv)     vec = 6'b000010;
      else if (op_store && !s1_d)     vec = 6'b000001;
    end
    exc_any = (vec != 6'b000000);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (flush || exc_any || (req && addr_ok)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. req does not look at flush: an addr_ok taken in the flush cycle is a real
  // memory transaction and is counted as cancelled instead.
  always_comb begin
    in_ready  = (state == S_IDLE);
    dbg_state = state;
    req       = issue && !exc_any && (outst_cnt < CNT_W'(MAX_OUTST));
    exc_valid = issue && exc_any && !flush;
    exc_vec   = exc_valid ? vec : 6'b000000;
    exc_badv  = exc_valid ? op_vaddr : 32'd0;
    s1_vppn     = op_vaddr[31:13];
    s1_va_bit12 = op_vaddr[12];
    datm        = issue ? xlat_mat : 2'd0;
    resp_valid  = data_ok && (cancel_cnt == '0) && !flush;

    sram.data_sram_req   = req;
    sram.data_sram_wr    = issue && op_store;
    sram.data_sram_size  = issue ? op_size : 2'd0;
    sram.data_sram_addr  = issue ? xlat_paddr : 32'd0;
    sram.data_sram_wstrb = 4'b0000;
    sram.data_sram_wdata = 32'd0;
    if (issue && op_store) begin
      case (op_size)
        2'd0: begin
          sram.data_sram_wstrb = 4'b0001 << op_vaddr[1:0];
          sram.data_sram_wdata = {4{op_wdata[7:0]}};
        end
        2'd1: begin
          sram.data_sram_wstrb = op_vaddr[1] ? 4'b1100 : 4'b0011;
          sram.data_sram_wdata = {2{op_wdata[15:0]}};
        end
        default: begin
          sram.data_sram_wstrb = 4'b1111;
          sram.data_sram_wdata = op_wdata;
        end
      endcase
    end
  end

  assign outst_nxt = outst_cnt + CNT_W'(req && addr_ok) - CNT_W'(data_ok);

  // Held op and in-flight / cancelled counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_vaddr   <= 32'd0;
      op_load    <= 1'b0;
      op_store   <= 1'b0;
      op_size    <= 2'd0;
      op_wdata   <= 32'd0;
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      if (accept) begin
        op_vaddr <= in_vaddr;
        op_load  <= in_is_load;
        op_store <= in_is_store;
        op_size  <= in_size;
        op_wdata <= in_wdata;
      end
      outst_cnt <= outst_nxt;
      if (flush)                            cancel_cnt <= outst_nxt;
      else if (data_ok && cancel_cnt != '0) cancel_cnt <= cancel_cnt - CNT_W'(1);
    end
  end

  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    data_ok |-> (outst_cnt != '0));

endmodule

// File: tb/tb_ex_lsu_req_unit.sv
// Directed bench for ex_lsu_req_unit: one task per scenario, inline checks, one summary line.
module tb_ex_lsu_req_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [31:0] in_vaddr, in_wdata;
  logic [1:0]  in_size;
  logic        flush;
  logic [1:0]  crmd_plv, crmd_datm;
  logic        csr_direct;
  logic [5:0]  dmw_vseg, dmw_pseg;
  logic [1:0]  dmw_plv0, dmw_plv3;
  logic [3:0]  dmw_mat;
  logic [18:0] s1_vppn;
  logic        s1_va_bit12, s1_found, s1_v, s1_d;
  logic [19:0] s1_ppn;
  logic [5:0]  s1_ps;
  logic [1:0]  s1_plv, s1_mat, datm;
  logic        resp_valid, exc_valid, dbg_state;
  logic [5:0]  exc_vec;
  logic [31:0] exc_badv;
  logic [1:0]  outst_cnt;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  ex_lsu_req_unit_if sram ();

  ex_lsu_req_unit #(.N_DMW(2), .MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_size(in_size), .in_wdata(in_wdata), .flush(flush),
    .crmd_plv(crmd_plv), .csr_direct(csr_direct), .crmd_datm(crmd_datm),
    .dmw_vseg(dmw_vseg), .dmw_pseg(dmw_pseg), .dmw_plv0(dmw_plv0), .dmw_plv3(dmw_plv3), .dmw_mat(dmw_mat),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_found(s1_found), .s1_v(s1_v), .s1_d(s1_d),
    .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat),
    .sram(sram.master), .datm(datm), .resp_valid(resp_valid), .exc_valid(exc_valid),
    .exc_vec(exc_vec), .exc_badv(exc_badv), .outst_cnt(outst_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [31:0] a, input logic st, input logic [1:0] sz, input logic [31:0] d);
    in_vaddr = a; in_is_load = ~st; in_is_store = st; in_size = sz; in_wdata = d; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic finish_addr();
    sram.data_sram_addr_ok = 1'b1;
    cycle();
    sram.data_sram_addr_ok = 1'b0;
  endtask

  task automatic finish_data();
    sram.data_sram_data_ok = 1'b1;
    cycle();
    sram.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 0; in_vaddr = 0; in_is_load = 0; in_is_store = 0; in_size = 0; in_wdata = 0;
    flush = 0; crmd_plv = 0; csr_direct = 0; crmd_datm = 0; dmw_vseg = 0; dmw_pseg = 0;
    dmw_plv0 = 0; dmw_plv3 = 0; dmw_mat = 0; s1_found = 0; s1_v = 0; s1_d = 0; s1_ppn = 0;
    s1_ps = 0; s1_plv = 0; s1_mat = 0; sram.data_sram_addr_ok = 0; sram.data_sram_data_ok = 0;
    #12;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (sram.data_sram_req !== 1'b0) $display("FAIL rst_req got=%0b exp=0", sram.data_sram_req); else pass_cnt++;
    total_cnt++; if (sram.data_sram_addr !== 32'd0) $display("FAIL rst_addr got=%h exp=0", sram.data_sram_addr); else pass_cnt++;
    total_cnt++; if ({exc_valid, resp_valid, outst_cnt, dbg_state} !== 5'b0) $display("FAIL rst_misc got=%b exp=00000", {exc_valid, resp_valid, outst_cnt, dbg_state}); else pass_cnt++;
    @(negedge clk); resetn = 1'b1;
    cycle();
  endtask

  task automatic test_direct_load();
    csr_direct = 1; crmd_datm = 2'b01; crmd_plv = 0;
    in_vaddr = 32'h1C000004; in_is_load = 1; in_is_store = 0; in_size = 2; in_valid = 1; #1;
    total_cnt++; if (sram.data_sram_req !== 1'b0) $display("FAIL t1_req_accept_cycle got=%0b exp=0", sram.data_sram_req); else pass_cnt++;
    cycle(); in_valid = 0; #1;
    total_cnt++; if (sram.data_sram_req !== 1'b1) $display("FAIL t1_req got=%0b exp=1", sram.data_sram_req); else pass_cnt++;
    total_cnt++; if (sram.data_sram_addr !== 32'h1C000004) $display("FAIL t1_addr got=%h exp=1c000004", sram.data_sram_addr); else pass_cnt++;
    total_cnt++; if ({sram.data_sram_wr, sram.data_sram_wstrb} !== 5'b0) $display("FAIL t1_wr_wstrb got=%b exp=00000", {sram.data_sram_wr, sram.data_sram_wstrb}); else pass_cnt++;
    total_cnt++; if (datm !== 2'b01) $display("FAIL t1_datm got=%b exp=01", datm); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL t1_busy got=%0b exp=0", in_ready); else pass_cnt++;
    finish_addr(); #1;
    total_cnt++; if (outst_cnt !== 2'd1) $display("FAIL t1_outst_after_addr got=%0d exp=1", outst_cnt); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL t1_idle_after_addr got=%0b exp=1", in_ready); else pass_cnt++;
    sram.data_sram_data_ok = 1; #1;
    total_cnt++; if (resp_valid !== 1'b1) $display("FAIL t1_resp got=%0b exp=1", resp_valid); else pass_cnt++;
    cycle(); sram.data_sram_data_ok = 0; #1;
    total_cnt++; if (outst_cnt !== 2'd0) $display("FAIL t1_outst_after_data got=%0d exp=0", outst_cnt); else pass_cnt++;
  endtask

  task automatic test_dmw_store();
    csr_direct = 0; crmd_plv = 0; s1_found = 0;
    dmw_vseg = {3'd4, 3'd4}; dmw_pseg = {3'd5, 3'd0}; dmw_plv0 = 2'b11; dmw_plv3 = 2'b00; dmw_mat = {2'b10, 2'b01};
    accept_op(32'h80000003, 1'b1, 2'd0, 32'h123456A5); #1;
    total_cnt++; if (sram.data_sram_addr !== 32'h00000003) $display("FAIL t2_addr got=%h exp=00000003", sram.data_sram_addr); else pass_cnt++;
    total_cnt++; if (sram.data_sram_wstrb !== 4'b1000) $display("FAIL t2_wstrb got=%b exp=1000", sram.data_sram_wstrb); else pass_cnt++;
    total_cnt++; if (sram.data_sram_wdata !== 32'hA5A5A5A5) $display("FAIL t2_wdata got=%h exp=a5a5a5a5", sram.data_sram_wdata); else pass_cnt++;
    total_cnt++; if ({sram.data_sram_req, sram.data_sram_wr, sram.data_sram_size, datm, exc_valid} !== 7'b1100010) $display("FAIL t2_ctl got=%b exp=1100010", {sram.data_sram_req, sram.data_sram_wr, sram.data_sram_size, datm, exc_valid}); else pass_cnt++;
    finish_addr(); finish_data();
  endtask

  task automatic test_ale_tlbr();
    accept_op(32'h00001001, 1'b0, 2'd1, 32'd0); #1;
    total_cnt++; if ({exc_valid, exc_vec} !== 7'b1100000) $display("FAIL t3_ale_vec got=%b exp=1100000", {exc_valid, exc_vec}); else pass_cnt++;
    total_cnt++; if (exc_badv !== 32'h00001001) $display("FAIL t3_ale_badv got=%h exp=00001001", exc_badv); else pass_cnt++;
    total_cnt++; if (sram.data_sram_req !== 1'b0) $display("FAIL t3_ale_req got=%0b exp=0", sram.data_sram_req); else pass_cnt++;
    cycle();
    total_cnt++; if ({exc_valid, in_ready} !== 2'b01) $display("FAIL t3_ale_pulse_end got=%b exp=01", {exc_valid, in_ready}); else pass_cnt++;
    accept_op(32'h00002000, 1'b1, 2'd2, 32'd0); #1;
    total_cnt++; if ({exc_valid, exc_vec, sram.data_sram_req} !== 8'b10100000) $display("FAIL t3_tlbr got=%b exp=10100000", {exc_valid, exc_vec, sram.data_sram_req}); else pass_cnt++;
    total_cnt++; if (exc_badv !== 32'h00002000) $display("FAIL t3_tlbr_badv got=%h exp=00002000", exc_badv); else pass_cnt++;
    cycle();
  endtask

  task automatic test_tlb_perm();
    s1_found = 1; s1_v = 1; s1_d = 0; s1_plv = 0; s1_ps = 6'd12; s1_ppn = 20'h12345; s1_mat = 2'b10;
    crmd_plv = 3;
    accept_op(32'h00003000, 1'b1, 2'd2, 32'd0); #1;
    total_cnt++; if ({exc_valid, exc_vec} !== 7'b1000010) $display("FAIL t4_ppi got=%b exp=1000010", {exc_valid, exc_vec}); else pass_cnt++;
    cycle(); crmd_plv = 0;
    accept_op(32'h00003000, 1'b1, 2'd2, 32'd0); #1;
    total_cnt++; if ({exc_valid, exc_vec} !== 7'b1000001) $display("FAIL t4_pme got=%b exp=1000001", {exc_valid, exc_vec}); else pass_cnt++;
    cycle(); s1_v = 0;
    accept_op(32'h00003000, 1'b0, 2'd2, 32'd0); #1;
    total_cnt++; if ({exc_valid, exc_vec} !== 7'b1001000) $display("FAIL t4_pil got=%b exp=1001000", {exc_valid, exc_vec}); else pass_cnt++;
    cycle(); s1_v = 1; s1_d = 1; s1_ps = 6'd21;
    accept_op(32'h0013ABC8, 1'b0, 2'd2, 32'd0); #1;
    total_cnt++; if (sram.data_sram_addr !== 32'h1233ABC8) $display("FAIL t4_ps21_addr got=%h exp=1233abc8", sram.data_sram_addr); else pass_cnt++;
    total_cnt++; if ({s1_vppn, s1_va_bit12} !== {19'h0009D, 1'b0}) $display("FAIL t4_vppn got=%h/%0b exp=9d/0", s1_vppn, s1_va_bit12); else pass_cnt++;
    total_cnt++; if ({sram.data_sram_req, datm, exc_valid} !== 4'b1100) $display("FAIL t4_ps21_ctl got=%b exp=1100", {sram.data_sram_req, datm, exc_valid}); else pass_cnt++;
    finish_addr(); finish_data(); s1_ps = 6'd12;
    accept_op(32'h00005ABC, 1'b0, 2'd2, 32'd0); #1;
    total_cnt++; if ({sram.data_sram_addr, s1_va_bit12} !== {32'h12345ABC, 1'b1}) $display("FAIL t4_ps12_addr got=%h/%0b exp=12345abc/1", sram.data_sram_addr, s1_va_bit12); else pass_cnt++;
    finish_addr(); finish_data();
  endtask

  task automatic test_outstanding();
    csr_direct = 1;
    accept_op(32'h00000100, 1'b0, 2'd2, 32'd0); finish_addr();
    accept_op(32'h00000104, 1'b0, 2'd2, 32'd0); finish_addr(); #1;
    total_cnt++; if (outst_cnt !== 2'd2) $display("FAIL t5_two_inflight got=%0d exp=2", outst_cnt); else pass_cnt++;
    accept_op(32'h00000108, 1'b0, 2'd2, 32'd0); #1;
    total_cnt++; if (sram.data_sram_req !== 1'b0) $display("FAIL t5_third_held got=%0b exp=0", sram.data_sram_req); else pass_cnt++;
    cycle();
    total_cnt++; if ({sram.data_sram_req, in_ready} !== 2'b00) $display("FAIL t5_still_held got=%b exp=00", {sram.data_sram_req, in_ready}); else pass_cnt++;
    finish_data(); #1;
    total_cnt++; if ({sram.data_sram_req, outst_cnt} !== 3'b101) $display("FAIL t5_released got=%b exp=101", {sram.data_sram_req, outst_cnt}); else pass_cnt++;
    sram.data_sram_addr_ok = 1; sram.data_sram_data_ok = 1; #1;
    total_cnt++; if (resp_valid !== 1'b1) $display("FAIL t5_same_cycle_resp got=%0b exp=1", resp_valid); else pass_cnt++;
    cycle(); sram.data_sram_addr_ok = 0; sram.data_sram_data_ok = 0; #1;
    total_cnt++; if (outst_cnt !== 2'd1) $display("FAIL t5_same_cycle_cnt got=%0d exp=1", outst_cnt); else pass_cnt++;
    finish_data(); #1;
    total_cnt++; if (outst_cnt !== 2'd0) $display("FAIL t5_drained got=%0d exp=0", outst_cnt); else pass_cnt++;
  endtask

  task automatic test_flush_cancel();
    accept_op(32'h00000200, 1'b0, 2'd2, 32'd0); finish_addr();
    accept_op(32'h00000204, 1'b0, 2'd2, 32'd0); finish_addr();
    accept_op(32'h00000208, 1'b0, 2'd2, 32'd0);
    sram.data_sram_data_ok = 1; #1;
    total_cnt++; if (resp_valid !== 1'b1) $display("FAIL t6_live_resp got=%0b exp=1", resp_valid); else pass_cnt++;
    cycle(); sram.data_sram_data_ok = 0;
    sram.data_sram_addr_ok = 1; flush = 1; #1;
    total_cnt++; if ({sram.data_sram_req, exc_valid} !== 2'b10) $display("FAIL t6_flush_req got=%b exp=10", {sram.data_sram_req, exc_valid}); else pass_cnt++;
    cycle(); sram.data_sram_addr_ok = 0; flush = 0; #1;
    total_cnt++; if ({outst_cnt, in_ready} !== 3'b101) $display("FAIL t6_after_flush got=%b exp=101", {outst_cnt, in_ready}); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      sram.data_sram_data_ok = 1; #1;
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL t6_cancelled_resp%0d got=%0b exp=0", k, resp_valid); else pass_cnt++;
      cycle(); sram.data_sram_data_ok = 0;
    end
    accept_op(32'h0000020C, 1'b0, 2'd2, 32'd0); finish_addr();
    sram.data_sram_data_ok = 1; #1;
    total_cnt++; if (resp_valid !== 1'b1) $display("FAIL t6_next_resp got=%0b exp=1", resp_valid); else pass_cnt++;
    cycle(); sram.data_sram_data_ok = 0;
    accept_op(32'h00001001, 1'b0, 2'd1, 32'd0);
    flush = 1; #1;
    total_cnt++; if ({exc_valid, exc_vec, sram.data_sram_req} !== 8'b0) $display("FAIL t6_flush_no_exc got=%b exp=00000000", {exc_valid, exc_vec, sram.data_sram_req}); else pass_cnt++;
    cycle(); flush = 0; #1;
    total_cnt++; if ({in_ready, exc_valid, outst_cnt} !== 4'b1000) $display("FAIL t6_flush_idle got=%b exp=1000", {in_ready, exc_valid, outst_cnt}); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    accept_op(32'h00000300, 1'b1, 2'd2, 32'hDEADBEEF); finish_addr();
    accept_op(32'h00000304, 1'b1, 2'd2, 32'hDEADBEEF); #1;
    total_cnt++; if (sram.data_sram_req !== 1'b1) $display("FAIL t7_pre_reset_req got=%0b exp=1", sram.data_sram_req); else pass_cnt++;
    #1 resetn = 1'b0; #1;
    total_cnt++; if ({sram.data_sram_req, in_ready, outst_cnt, sram.data_sram_wstrb} !== 8'b01000000) $display("FAIL t7_async_clear got=%b exp=01000000", {sram.data_sram_req, in_ready, outst_cnt, sram.data_sram_wstrb}); else pass_cnt++;
    @(negedge clk); resetn = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_direct_load();
    test_dmw_store();
    test_ale_tlbr();
    test_tlb_perm();
    test_outstanding();
    test_flush_cancel();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
